// File: rtl/sram_fb_arbiter.sv
// sram_fb_arbiter: single-port arbiter for the external 256Kx16 SRAM framebuffer.
// Scan-out reads take absolute priority and return data exactly two cycles
// after the request. Rasterizer writes are queued in a small FIFO and drain
// into the SRAM through a two-cycle SETUP/PULSE sequence whenever the read
// port leaves the bus free.
module sram_fb_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 12
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    // scan-out read port
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    // rasterizer write port
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    // external SRAM
    output logic [ADDR_W-1:0]             SRAM_ADDR,
    inout  wire  [15:0]                   SRAM_DQ,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_OE_N,
    output logic                          SRAM_CE_N,
    output logic                          SRAM_UB_N,
    output logic                          SRAM_LB_N
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE
    } state_t;

    state_t state_reg, state_next;

    // write FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              push, pop;
    logic [PTR_W-1:0]  head_idx;
    logic [CNT_W-1:0]  count_after_pop;

    // registered SRAM pin state
    logic [ADDR_W-1:0] sram_addr_reg;
    logic              we_n_reg, oe_n_reg, dq_oe_reg;
    logic [DATA_W-1:0] dq_out_reg;

    // read return path
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    assign wr_ready   = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push       = wr_valid & wr_ready;
    // the head entry leaves the FIFO once its WE_N pulse has been driven
    assign pop        = (state_reg == ST_WR_PULSE);
    assign fifo_count = count_reg;

    // when the head pops this cycle, the next write must see the following entry
    assign head_idx        = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign count_after_pop = count_reg - CNT_W'(pop);

    // FIFO entry storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= wr_addr;
            fifo_data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // next state: reads pre-empt everything except a pulse already under way
    always_comb begin
        state_next = ST_IDLE;
        if (rd_req)
            state_next = ST_RD;
        else if (state_reg == ST_WR_SETUP)
            state_next = ST_WR_PULSE;
        else if (count_after_pop != '0)
            state_next = ST_WR_SETUP;
    end

    // SRAM control/address/data registers follow the state being entered
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
        end else begin
            oe_n_reg  <= (state_next != ST_RD);
            we_n_reg  <= (state_next != ST_WR_PULSE);
            dq_oe_reg <= (state_next == ST_WR_SETUP) || (state_next == ST_WR_PULSE);
            if (state_next == ST_RD) begin
                sram_addr_reg <= rd_addr;
            end else if (state_next != ST_IDLE) begin
                sram_addr_reg <= fifo_addr_mem[head_idx];
                dq_out_reg    <= fifo_data_mem[head_idx];
            end
        end
    end

    // capture the SRAM word at the end of each RD cycle; data holds otherwise
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= (state_reg == ST_RD);
            if (state_reg == ST_RD)
                rd_data_reg <= SRAM_DQ[DATA_W-1:0];
        end
    end

    // per-bit tristate drive; bits above the pixel width are driven low
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dq
            if (gi < DATA_W) begin : g_pix
                assign SRAM_DQ[gi] = dq_oe_reg ? dq_out_reg[gi] : 1'bz;
            end else begin : g_pad
                assign SRAM_DQ[gi] = dq_oe_reg ? 1'b0 : 1'bz;
            end
        end
    endgenerate

    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_sram_fb_arbiter.sv
// tb_sram_fb_arbiter: directed bench for the SRAM framebuffer arbiter with a
// behavioural 256Kx16 asynchronous SRAM model attached to the pins.
module tb_sram_fb_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  fifo_count;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    // SRAM model state
    logic [15:0] sram_mem [0:262143];
    logic [17:0] wlog [0:63];
    int          wcount = 0;
    logic        bd_we = 1'b0;
    logic [17:0] bd_addr = '0;
    logic [15:0] bd_data = '0;
    logic        probe_en = 1'b0;
    logic        tb_drive;
    logic [15:0] tb_word;

    sram_fb_arbiter #(.FIFO_DEPTH(8), .ADDR_W(18), .DATA_W(12)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fifo_count(fifo_count),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // SRAM read drive; probe_en forces a known pattern to prove the DUT is hi-Z
    assign tb_drive = (!SRAM_OE_N && SRAM_WE_N) || probe_en;
    assign tb_word  = probe_en ? 16'hA5A5 : sram_mem[SRAM_ADDR];
    assign SRAM_DQ  = tb_drive ? tb_word : 16'hzzzz;

    // SRAM write capture (one word per WE_N-low cycle) plus backdoor preload
    always @(posedge CLOCK_50) begin
        if (!SRAM_WE_N) begin
            sram_mem[SRAM_ADDR]  <= SRAM_DQ;
            wlog[wcount[5:0]]    <= SRAM_ADDR;
            wcount               <= wcount + 1;
        end else if (bd_we) begin
            sram_mem[bd_addr] <= bd_data;
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic preload(input logic [17:0] base, input int n, input int mult, input int offs);
        bd_we = 1'b1;
        for (int i = 0; i < n; i++) begin
            bd_addr = base + 18'(i);
            bd_data = 16'((i * mult + offs) & 12'hFFF);
            step();
        end
        bd_we = 1'b0;
    endtask

    task automatic do_read(input logic [17:0] addr, output logic [11:0] data, output logic valid);
        rd_req  = 1'b1;
        rd_addr = addr;
        step();
        rd_req = 1'b0;
        step();
        valid = rd_valid;
        data  = rd_data;
        $display("read  addr=%05h data=%03h valid=%0b", addr, data, valid);
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        step(); step();
        probe_en = 1'b1; #1;
        checks++; if (SRAM_DQ !== 16'hA5A5) begin errors++; $display("FAIL reset_dq_hiz: got %h expected a5a5", SRAM_DQ); end
        probe_en = 1'b0; #1;
        checks++; if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", SRAM_ADDR); end
        checks++; if ({SRAM_WE_N, SRAM_OE_N} !== 2'b11) begin errors++; $display("FAIL reset_we_oe: got %b expected 11", {SRAM_WE_N, SRAM_OE_N}); end
        checks++; if ({rd_valid, rd_data} !== 13'h0) begin errors++; $display("FAIL reset_rd: got %b/%h expected 0/000", rd_valid, rd_data); end
        checks++; if ({wr_ready, fifo_count} !== 5'b1_0000) begin errors++; $display("FAIL reset_fifo: got ready=%b count=%0d expected 1/0", wr_ready, fifo_count); end
        checks++; if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000) begin errors++; $display("FAIL reset_ce_ub_lb: got %b expected 000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}); end
        @(negedge CLOCK_50); reset = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_single_read();
        int w0;
        preload(18'h00010, 1, 0, 12'h0F0);
        preload(18'h00300, 1, 0, 12'h555);
        w0 = wcount;
        rd_req = 1'b1; rd_addr = 18'h00010;
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_lat_t1: got valid=%b expected 0", rd_valid); end
        checks++; if ({SRAM_OE_N, SRAM_ADDR} !== {1'b0, 18'h00010}) begin errors++; $display("FAIL read_rd_pins: got oe=%b addr=%h expected 0/00010", SRAM_OE_N, SRAM_ADDR); end
        step();
        checks++; if ({rd_valid, rd_data} !== {1'b1, 12'h0F0}) begin errors++; $display("FAIL read_lat_t2: got %b/%h expected 1/0f0", rd_valid, rd_data); end
        step();
        checks++; if ({rd_valid, rd_data} !== {1'b0, 12'h0F0}) begin errors++; $display("FAIL read_hold: got %b/%h expected 0/0f0", rd_valid, rd_data); end
        checks++; if (wcount !== w0) begin errors++; $display("FAIL read_no_we: got %0d pulses expected 0", wcount - w0); end
        $display("single read addr=00010 data=%03h", rd_data);
    endtask

    task automatic test_write_drain();
        int w0;
        logic [11:0] d;
        logic v;
        w0 = wcount;
        wr_valid = 1'b1; wr_addr = 18'h00001; wr_data = 12'h00F;
        step();
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL drain_cnt1: got %0d expected 1", fifo_count); end
        wr_addr = 18'h00002; wr_data = 12'hFF0;
        step();
        checks++; if ({SRAM_WE_N, SRAM_ADDR, SRAM_DQ} !== {1'b1, 18'h00001, 16'h000F}) begin errors++; $display("FAIL drain_setup: got we=%b addr=%h dq=%h expected 1/00001/000f", SRAM_WE_N, SRAM_ADDR, SRAM_DQ); end
        wr_addr = 18'h00003; wr_data = 12'h123;
        step();
        wr_valid = 1'b0;
        checks++; if ({fifo_count, SRAM_WE_N} !== {4'd3, 1'b0}) begin errors++; $display("FAIL drain_pulse: got count=%0d we=%b expected 3/0", fifo_count, SRAM_WE_N); end
        step();
        checks++; if ({fifo_count, SRAM_WE_N, SRAM_ADDR} !== {4'd2, 1'b1, 18'h00002}) begin errors++; $display("FAIL drain_second: got count=%0d we=%b addr=%h expected 2/1/00002", fifo_count, SRAM_WE_N, SRAM_ADDR); end
        step(); step(); step(); step();
        checks++; if ({fifo_count, SRAM_WE_N, SRAM_OE_N} !== {4'd0, 2'b11}) begin errors++; $display("FAIL drain_empty: got count=%0d we=%b oe=%b expected 0/1/1", fifo_count, SRAM_WE_N, SRAM_OE_N); end
        checks++; if (wcount - w0 !== 3) begin errors++; $display("FAIL drain_pulses: got %0d expected 3", wcount - w0); end
        checks++; if ({wlog[w0[5:0]], wlog[6'(w0 + 1)], wlog[6'(w0 + 2)]} !== {18'h1, 18'h2, 18'h3}) begin errors++; $display("FAIL drain_order: got %h %h %h expected 1 2 3", wlog[w0[5:0]], wlog[6'(w0 + 1)], wlog[6'(w0 + 2)]); end
        do_read(18'h00001, d, v);
        checks++; if ({v, d} !== {1'b1, 12'h00F}) begin errors++; $display("FAIL readback1: got %b/%h expected 1/00f", v, d); end
        do_read(18'h00002, d, v);
        checks++; if ({v, d} !== {1'b1, 12'hFF0}) begin errors++; $display("FAIL readback2: got %b/%h expected 1/ff0", v, d); end
        do_read(18'h00003, d, v);
        checks++; if ({v, d} !== {1'b1, 12'h123}) begin errors++; $display("FAIL readback3: got %b/%h expected 1/123", v, d); end
    endtask

    task automatic test_fifo_full();
        int w0;
        int budget;
        logic ord_ok;
        w0 = wcount;
        rd_req = 1'b1; rd_addr = 18'h00010;
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 18'h00040 + 18'(i);
            wr_data = 12'h800 + 12'(i);
            step();
        end
        wr_addr = 18'h00048; wr_data = 12'h808;
        step(); step();
        checks++; if ({fifo_count, wr_ready} !== {4'd8, 1'b0}) begin errors++; $display("FAIL full_hold: got count=%0d ready=%b expected 8/0", fifo_count, wr_ready); end
        checks++; if (wcount !== w0) begin errors++; $display("FAIL full_no_we: got %0d pulses expected 0", wcount - w0); end
        rd_req = 1'b0;
        step();
        checks++; if ({fifo_count, wr_ready} !== {4'd8, 1'b0}) begin errors++; $display("FAIL full_setup: got count=%0d ready=%b expected 8/0", fifo_count, wr_ready); end
        step(); step();
        checks++; if ({fifo_count, wr_ready} !== {4'd7, 1'b1}) begin errors++; $display("FAIL full_first_pop: got count=%0d ready=%b expected 7/1", fifo_count, wr_ready); end
        step();
        wr_valid = 1'b0;
        checks++; if ({fifo_count, wr_ready} !== {4'd8, 1'b0}) begin errors++; $display("FAIL full_refill: got count=%0d ready=%b expected 8/0", fifo_count, wr_ready); end
        budget = 100;
        while (fifo_count != 0 && budget > 0) begin
            step();
            budget--;
        end
        step();
        checks++; if (wcount - w0 !== 9) begin errors++; $display("FAIL full_drain_pulses: got %0d expected 9", wcount - w0); end
        ord_ok = 1'b1;
        for (int i = 0; i < 9; i++)
            if (wlog[6'(w0 + i)] !== 18'h00040 + 18'(i)) ord_ok = 1'b0;
        checks++; if (ord_ok !== 1'b1) begin errors++; $display("FAIL full_order: got out-of-order drain, first=%h expected 00040", wlog[w0[5:0]]); end
        $display("fifo full/drain: %0d writes committed", wcount - w0);
    endtask

    task automatic test_read_abort();
        int w0;
        logic [11:0] d;
        logic v;
        w0 = wcount;
        wr_valid = 1'b1; wr_addr = 18'h00100; wr_data = 12'hABC;
        step();
        wr_valid = 1'b0;
        step();
        checks++; if ({SRAM_WE_N, SRAM_ADDR, SRAM_DQ} !== {1'b1, 18'h00100, 16'h0ABC}) begin errors++; $display("FAIL abort_setup: got we=%b addr=%h dq=%h expected 1/00100/0abc", SRAM_WE_N, SRAM_ADDR, SRAM_DQ); end
        rd_req = 1'b1; rd_addr = 18'h00010;
        step();
        rd_req = 1'b0;
        checks++; if ({SRAM_WE_N, SRAM_OE_N, fifo_count, SRAM_ADDR} !== {1'b1, 1'b0, 4'd1, 18'h00010}) begin errors++; $display("FAIL abort_rd: got we=%b oe=%b count=%0d addr=%h expected 1/0/1/00010", SRAM_WE_N, SRAM_OE_N, fifo_count, SRAM_ADDR); end
        step();
        checks++; if ({rd_valid, rd_data, SRAM_ADDR, wcount - w0} !== {1'b1, 12'h0F0, 18'h00100, 0}) begin errors++; $display("FAIL abort_retry: got valid=%b data=%h addr=%h pulses=%0d expected 1/0f0/00100/0", rd_valid, rd_data, SRAM_ADDR, wcount - w0); end
        step();
        checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL abort_pulse: got we=%b expected 0", SRAM_WE_N); end
        step();
        checks++; if ({fifo_count, wcount - w0} !== {4'd0, 1}) begin errors++; $display("FAIL abort_done: got count=%0d pulses=%0d expected 0/1", fifo_count, wcount - w0); end
        do_read(18'h00100, d, v);
        checks++; if ({v, d} !== {1'b1, 12'hABC}) begin errors++; $display("FAIL abort_readback: got %b/%h expected 1/abc", v, d); end
    endtask

    task automatic test_back_to_back();
        int good;
        logic [11:0] exp_d;
        preload(18'h20000, 640, 7, 3);
        good = 0;
        for (int c = 0; c <= 642; c++) begin
            rd_req  = (c < 640);
            rd_addr = 18'h20000 + 18'(c);
            step();
            if (c >= 1 && c - 1 < 640) begin
                exp_d = 12'(((c - 1) * 7 + 3) & 12'hFFF);
                checks++;
                if ({rd_valid, rd_data} !== {1'b1, exp_d}) begin
                    errors++;
                    $display("FAIL b2b_read[%0d]: got %b/%h expected 1/%h", c - 1, rd_valid, rd_data, exp_d);
                end else begin
                    good++;
                end
            end else if (c == 642) begin
                checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got valid=%b expected 0", rd_valid); end
            end
        end
        rd_req = 1'b0;
        $display("back-to-back reads: %0d of 640 returned on time", good);
    endtask

    task automatic test_reset_mid_write();
        int w0;
        logic [11:0] d;
        logic v;
        w0 = wcount;
        wr_valid = 1'b1; wr_addr = 18'h00300; wr_data = 12'h111;
        step();
        wr_addr = 18'h00301; wr_data = 12'h222;
        step();
        wr_valid = 1'b0;
        step();
        checks++; if ({SRAM_WE_N, SRAM_ADDR} !== {1'b0, 18'h00300}) begin errors++; $display("FAIL rstw_pulse: got we=%b addr=%h expected 0/00300", SRAM_WE_N, SRAM_ADDR); end
        #4 reset = 1'b1;
        #1;
        checks++; if ({SRAM_WE_N, SRAM_OE_N, fifo_count, wr_ready} !== {2'b11, 4'd0, 1'b1}) begin errors++; $display("FAIL rstw_async: got we=%b oe=%b count=%0d ready=%b expected 1/1/0/1", SRAM_WE_N, SRAM_OE_N, fifo_count, wr_ready); end
        probe_en = 1'b1; #1;
        checks++; if (SRAM_DQ !== 16'hA5A5) begin errors++; $display("FAIL rstw_dq_hiz: got %h expected a5a5", SRAM_DQ); end
        probe_en = 1'b0;
        step(); step();
        @(negedge CLOCK_50); reset = 1'b0;
        step(); step(); step();
        checks++; if ({fifo_count, wcount - w0} !== {4'd0, 0}) begin errors++; $display("FAIL rstw_discard: got count=%0d pulses=%0d expected 0/0", fifo_count, wcount - w0); end
        do_read(18'h00300, d, v);
        checks++; if ({v, d} !== {1'b1, 12'h555}) begin errors++; $display("FAIL rstw_unwritten: got %b/%h expected 1/555", v, d); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_drain();
        test_fifo_full();
        test_read_abort();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
